bcd_serial_dabble: RTL and testbench

//   Parametrised sequential binary-to-BCD converter (shift-and-add-3 / double dabble).

---
 rtl/bcd_serial_dabble.sv | 122 ++++++++++++
 tb/tb_bcd_serial_dabble.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_dabble.sv
// bcd_serial_dabble
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
// It converts an unsigned WIDTH-bit value into DIGITS packed BCD digits.
// A start is accepted at edge T. One iteration runs on each of the edges
// T+1 .. T+WIDTH. The result registers and a one-cycle valid pulse update at
// edge T+WIDTH.
// If the value needs more digits than DIGITS provides, bcd holds the value
// modulo 10^DIGITS and overflow is set. The carry that leaves the top digit
// during any shift is exactly the part of the value at or above 10^DIGITS.
// All outputs are registered, so there is no combinational path from the
// inputs to the outputs.

module bcd_serial_dabble #(
    parameter int WIDTH  = 8,   // binary input width, 1..32
    parameter int DIGITS = 3    // BCD output digits, 1..10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow,
    output logic [DIGITS-1:0]     sig
);

    localparam int BCDW = 4 * DIGITS;       // width of the BCD field
    localparam int SRW  = BCDW + WIDTH;     // BCD field above the binary field
    localparam int CNTW = 6;                // holds WIDTH up to 32

    localparam logic [CNTW-1:0]   CNT_LOAD = CNTW'(WIDTH);
    localparam logic [CNTW-1:0]   CNT_LAST = CNTW'(1);
    localparam logic [DIGITS-1:0] SIG_RST  = DIGITS'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state;
    logic [SRW-1:0]    sr;         // {bcd digits, remaining binary bits}
    logic [CNTW-1:0]   cnt;        // iterations still to run
    logic              ovf_acc;    // sticky carry out of the top digit

    // Values produced by one iteration, computed from the current register.
    logic [SRW-1:0]    corrected;
    logic [SRW-1:0]    shifted;
    logic              acc_next;
    logic [BCDW-1:0]   final_bcd;
    logic [DIGITS-1:0] sig_next;
    logic              any_nz;

    // One iteration: add 3 to every digit >= 5, then shift left by one bit.
    // This also gathers the significance mask of the digits after the shift.
    always_comb begin
        // NOTE: every variable gets a default before any conditional update, so no latch is inferred.
        corrected = sr;
        for (int i = 0; i < DIGITS; i++) begin
            if (sr[WIDTH + 4*i +: 4] >= 4'd5) begin
                corrected[WIDTH + 4*i +: 4] = sr[WIDTH + 4*i +: 4] + 4'd3;
            end
        end
        shifted   = corrected << 1;
        acc_next  = ovf_acc | corrected[SRW-1];
        final_bcd = shifted[WIDTH +: BCDW];

        // A digit is significant if it or any higher digit is nonzero.
        // The units digit is always shown.
        any_nz   = 1'b0;
        sig_next = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            any_nz      = any_nz | (final_bcd[4*i +: 4] != 4'd0);
            sig_next[i] = any_nz;
        end
        sig_next[0] = 1'b1;
    end

    // Control FSM and datapath registers; all outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sr       <= '0;
            cnt      <= '0;
            ovf_acc  <= 1'b0;
            busy     <= 1'b0;
            valid    <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
            sig      <= SIG_RST;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sr      <= {{BCDW{1'b0}}, bin};
                        cnt     <= CNT_LOAD;
                        ovf_acc <= 1'b0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr      <= shifted;
                    cnt     <= cnt - CNT_LAST;
                    ovf_acc <= acc_next;
                    if (cnt == CNT_LAST) begin
                        bcd      <= final_bcd;
                        overflow <= acc_next;
                        sig      <= sig_next;
                        valid    <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_dabble.sv
// Testbench for bcd_serial_dabble.
// Three instances are driven from a shared clock and reset: 8-bit/3-digit,
// 8-bit/2-digit and 16-bit/5-digit. Expected results come from a decimal
// reference model that uses plain division and modulo.

module tb_bcd_serial_dabble;

    logic        clk;
    logic        rst_n;

    logic        start8, busy8, valid8, ovf8;
    logic [7:0]  bin8;
    logic [11:0] bcd8;
    logic [2:0]  sig8;

    logic        start2, busy2, valid2, ovf2;
    logic [7:0]  bin2;
    logic [7:0]  bcd2;
    logic [1:0]  sig2;

    logic        start16, busy16, valid16, ovf16;
    logic [15:0] bin16;
    logic [19:0] bcd16;
    logic [4:0]  sig16;

    int checks = 0;
    int errors = 0;

    bcd_serial_dabble #(.WIDTH(8), .DIGITS(3)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .bin(bin8), .busy(busy8),
        .valid(valid8), .bcd(bcd8), .overflow(ovf8), .sig(sig8)
    );

    bcd_serial_dabble #(.WIDTH(8), .DIGITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .bin(bin2), .busy(busy2),
        .valid(valid2), .bcd(bcd2), .overflow(ovf2), .sig(sig2)
    );

    bcd_serial_dabble #(.WIDTH(16), .DIGITS(5)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .bin(bin16), .busy(busy16),
        .valid(valid16), .bcd(bcd16), .overflow(ovf16), .sig(sig16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic longint unsigned pow10(input int n);
        longint unsigned p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [39:0] ref_bcd(input longint unsigned v, input int d);
        logic [39:0] r = '0;
        longint unsigned t = v;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input longint unsigned v, input int d);
        return v >= pow10(d);
    endfunction

    function automatic logic [9:0] ref_sig(input longint unsigned v, input int d);
        logic [9:0] s = '0;
        longint unsigned m = v % pow10(d);
        for (int i = 0; i < d; i++) s[i] = (i == 0) || ((m / pow10(i)) != 0);
        return s;
    endfunction

    function automatic logic [50:0] ref_all(input longint unsigned v, input int d);
        return {ref_bcd(v, d), ref_ovf(v, d), ref_sig(v, d)};
    endfunction

    function automatic int digits_of(input int sel);
        return (sel == 0) ? 3 : (sel == 1) ? 2 : 5;
    endfunction

    function automatic logic valid_of(input int sel);
        return (sel == 0) ? valid8 : (sel == 1) ? valid2 : valid16;
    endfunction

    function automatic logic [50:0] result_of(input int sel);
        case (sel)
            0:       return {40'(bcd8),  ovf8,  10'(sig8)};
            1:       return {40'(bcd2),  ovf2,  10'(sig2)};
            default: return {40'(bcd16), ovf16, 10'(sig16)};
        endcase
    endfunction

    // One start pulse on the selected instance. This returns the number of
    // cycles until valid (-1 on timeout) and the captured result.
    task automatic convert(input int sel, input int unsigned value,
                           output int lat, output logic [50:0] res);
        lat = -1;
        res = '0;
        case (sel)
            0:       begin bin8  = value[7:0];  start8  = 1'b1; end
            1:       begin bin2  = value[7:0];  start2  = 1'b1; end
            default: begin bin16 = value[15:0]; start16 = 1'b1; end
        endcase
        @(posedge clk); #1;
        start8 = 1'b0; start2 = 1'b0; start16 = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (valid_of(sel)) begin
                lat = c;
                res = result_of(sel);
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        checks++;
        if ({busy8, valid8, bcd8, ovf8, sig8} !== {1'b0, 1'b0, 12'h000, 1'b0, 3'b001}) begin
            errors++;
            $display("FAIL reset8: got busy=%b valid=%b bcd=%h ovf=%b sig=%b, want 0 0 000 0 001",
                     busy8, valid8, bcd8, ovf8, sig8);
        end
        checks++;
        if ({busy16, valid16, bcd16, ovf16, sig16} !== {1'b0, 1'b0, 20'h0, 1'b0, 5'b00001}) begin
            errors++;
            $display("FAIL reset16: got busy=%b valid=%b bcd=%h ovf=%b sig=%b, want 0 0 00000 0 00001",
                     busy16, valid16, bcd16, ovf16, sig16);
        end
    endtask

    task automatic test_directed();
        int unsigned vals[5] = '{255, 0, 7, 40, 109};
        int lat;
        logic [50:0] res;
        foreach (vals[k]) begin
            convert(0, vals[k], lat, res);
            checks++;
            if (lat !== 8) begin
                errors++;
                $display("FAIL latency8 bin=%0d: got %0d cycles, want 8", vals[k], lat);
            end
            checks++;
            if (res !== ref_all(vals[k], 3)) begin
                errors++;
                $display("FAIL result8 bin=%0d: got %h, want %h", vals[k], res, ref_all(vals[k], 3));
            end
        end
    endtask

    task automatic test_random();
        int unsigned v;
        int lat;
        logic [50:0] res;
        for (int k = 0; k < 20; k++) begin
            v = $urandom_range(255, 0);
            convert(0, v, lat, res);
            checks++;
            if (lat !== 8 || res !== ref_all(v, 3)) begin
                errors++;
                $display("FAIL random8 bin=%0d: got lat=%0d res=%h, want lat=8 res=%h",
                         v, lat, res, ref_all(v, 3));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic spacing_ok;
        start8 = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bin8 = 8'(i);
            @(posedge clk); #1;               // accepted edge T
            spacing_ok = 1'b1;
            for (int c = 1; c <= 8; c++) begin
                @(posedge clk); #1;
                if ((c < 8 && valid8) || (c == 8 && !valid8)) spacing_ok = 1'b0;
            end
            checks++;
            if (!spacing_ok) begin
                errors++;
                $display("FAIL b2b_spacing bin=%0d: valid not exactly at cycle 8 of 9", i);
            end
            checks++;
            if (result_of(0) !== ref_all(i, 3)) begin
                errors++;
                $display("FAIL b2b_result bin=%0d: got %h, want %h", i, result_of(0), ref_all(i, 3));
            end
        end
        start8 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_ignore_start();
        int unsigned a;
        int nval, first_c;
        logic [50:0] res;
        a = 200 + $urandom_range(49, 0);
        nval = 0; first_c = -1; res = '0;
        bin8 = 8'(a); start8 = 1'b1;
        @(posedge clk); #1;                   // T
        start8 = 1'b0;
        @(posedge clk); #1;                   // T+1
        @(posedge clk); #1;                   // T+2
        bin8 = 8'd99; start8 = 1'b1;
        @(posedge clk); #1;                   // T+3, must be ignored
        start8 = 1'b0; bin8 = 8'd0;
        for (int c = 4; c <= 22; c++) begin
            @(posedge clk); #1;
            if (valid8) begin
                nval++;
                if (first_c < 0) begin first_c = c; res = result_of(0); end
            end
        end
        checks++;
        if (nval !== 1 || first_c !== 8) begin
            errors++;
            $display("FAIL ignore_start_pulses: got %0d pulses first at %0d, want 1 at 8", nval, first_c);
        end
        checks++;
        if (res !== ref_all(a, 3)) begin
            errors++;
            $display("FAIL ignore_start_value bin=%0d: got %h, want %h", a, res, ref_all(a, 3));
        end
    endtask

    task automatic test_reset_mid();
        int stray;
        stray = 0;
        bin8 = 8'd255; start8 = 1'b1;
        @(posedge clk); #1;                   // T
        start8 = 1'b0;
        for (int c = 1; c <= 4; c++) begin @(posedge clk); #1; end   // just after T+4
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy8, valid8, bcd8, ovf8, sig8} !== {1'b0, 1'b0, 12'h000, 1'b0, 3'b001}) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b valid=%b bcd=%h ovf=%b sig=%b, want 0 0 000 0 001",
                     busy8, valid8, bcd8, ovf8, sig8);
        end
        #3 rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (valid8 || busy8 || valid2 || valid16) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL post_reset_quiet: got %0d active cycles, want 0", stray);
        end
    endtask

    task automatic test_overflow();
        int unsigned v2[6] = '{99, 100, 255, 0, 10, 150};
        int lat;
        logic [50:0] res;
        int unsigned v;
        foreach (v2[k]) begin
            convert(1, v2[k], lat, res);
            checks++;
            if (lat !== 8 || res !== ref_all(v2[k], 2)) begin
                errors++;
                $display("FAIL digits2 bin=%0d: got lat=%0d res=%h, want lat=8 res=%h",
                         v2[k], lat, res, ref_all(v2[k], 2));
            end
        end
        for (int k = 0; k < 8; k++) begin
            v = (k == 0) ? 65535 : (k == 1) ? 0 : $urandom_range(65535, 0);
            convert(2, v, lat, res);
            checks++;
            if (lat !== 16 || res !== ref_all(v, 5)) begin
                errors++;
                $display("FAIL width16 bin=%0d: got lat=%0d res=%h, want lat=16 res=%h",
                         v, lat, res, ref_all(v, 5));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start8 = 1'b0; start2 = 1'b0; start16 = 1'b0;
        bin8 = '0; bin2 = '0; bin16 = '0;
        #23 rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        test_overflow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
